apb_uart_bus_arbiter: RTL and testbench
=======================================

// Module: apb_uart_bus_arbiter
// PURPOSE
//  Shares one APB master port to the UART register slave between NUM_REQ requesters (e.g. CPU bridge, DMA).
//  Round-robin grant, one transfer at a time; generates APB SETUP/ACCESS phases and returns rdata/err to the winner.
//  Aborts stalled transfers after TIMEOUT_CYC cycles, because the UART slave holds pready=0 on unmapped addresses.
// PARAMETERS
//  NUM_REQ      2    number of requesters (>=2)
//  ADDR_W       12   APB address width
//  DATA_W       32   APB data width
//  TIMEOUT_CYC  16   max ACCESS cycles waiting for pready; 0 = timeout disabled
// PORTS
//  pclk        in   1               APB clock; all logic on rising edge
//  presetn     in   1               reset, asynchronous, active-low
//  req_valid   in   NUM_REQ         per-requester transfer request; held until req_ready
//  req_write   in   NUM_REQ         1=write, 0=read
//  req_addr    in   NUM_REQ*ADDR_W  flattened; slice i = requester i
//  req_wdata   in   NUM_REQ*DATA_W  flattened write data
//  req_strb    in   NUM_REQ*4       flattened byte strobes
//  req_ready   out  NUM_REQ         one-hot 1-cycle pulse: request i accepted and captured
//  rsp_valid   out  NUM_REQ         one-hot 1-cycle pulse: transfer for requester i finished
//  rsp_rdata   out  DATA_W          read data; valid with rsp_valid (0 for writes/timeouts)
//  rsp_err     out  1               pslverr or timeout; valid with rsp_valid
//  timeout_o   out  1               1-cycle pulse when a transfer is aborted by timeout
//  psel        out  1               APB select
//  penable     out  1               APB enable
//  pwrite      out  1               APB direction
//  paddr       out  ADDR_W          APB address
//  pstrb       out  4               APB strobes
//  pwdata      out  DATA_W          APB write data
//  pready      in   1               APB ready from slave
//  pslverr     in   1               APB error from slave
//  prdata      in   DATA_W          APB read data
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0 (requester 0 highest priority), every output 0, timeout counter 0.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE; encoding in the shared package.
//  - IDLE: if any req_valid, arbiter picks winner w; req_ready[w]=1 this cycle (combinational from IDLE & grant);
//    w's write/addr/wdata/strb are registered on this edge; next state SETUP. No request: stay IDLE, outputs 0.
//  - SETUP (1 cycle): psel=1, penable=0, APB outputs driven from the captured registers -> ACCESS.
//  - ACCESS: psel=1, penable=1, APB outputs stable. On pready=1: register rsp_rdata=(read ? prdata : 0),
//    rsp_err=pslverr, rsp_valid[w]=1 in the next cycle; state -> IDLE.
//  - Timeout: counter clears on SETUP, increments per ACCESS cycle with pready=0; when it reaches
//    TIMEOUT_CYC-1 with pready still 0, transfer aborts: psel/penable drop next cycle, rsp_valid[w]=1,
//    rsp_err=1, rsp_rdata=0, timeout_o=1 (same cycle as rsp_valid); -> IDLE. pready on the abort cycle wins.
//  - Latency: req_valid in IDLE -> rsp_valid 3 cycles later with zero-wait slave (accept, SETUP, ACCESS, rsp).
//  - Back-to-back: at least one IDLE cycle between transfers; APB bus idle (psel=0) in that cycle.
//  - Round-robin: on accept, pointer <- w+1 mod NUM_REQ; search starts at pointer. Simultaneous requests
//    are served in rotating order; no requester waits more than NUM_REQ-1 transfers.
//  - req_valid dropping before req_ready: request withdrawn, no effect. Changes to req_* after
//    req_ready are ignored (captured copy is used).
//  - rsp_valid/rsp_err/rsp_rdata/timeout_o are single-cycle; rsp_rdata/rsp_err return to 0 the next cycle.
//  - presetn asserted mid-transfer: immediate return to IDLE, all outputs 0; no rsp_valid issued for the
//    in-flight transfer; requesters reissue after reset.
//  - Unused upper address/data bits are passed through unchanged; no address decode in this block.
// STRUCTURE
//  - Package uart_apb_pkg: apb_mstate_e {APB_M_IDLE, APB_M_SETUP, APB_M_ACCESS}; UART register address
//    localparams (TX_DATA 'h0, RX_DATA 'h4, CFG 'h8, CTRL 'hC, STT 'h10) shared with the slave and benches.
//  - Sub-module rr_arbiter #(N): inputs req[N], advance; outputs one-hot grant[N], grant index; holds the pointer.
//  - Top: FSM, capture registers, timeout counter, response registers.
// TESTING
//  1 Single write: req0 write addr 'h8 wdata 'h15 strb 'hF, pready=1 in first ACCESS -> SETUP/ACCESS each one
//    cycle, paddr='h8 pwdata='h15, rsp_valid[0]=1 exactly 3 cycles after req_valid, rsp_err=0.
//  2 Read with wait states: req1 read 'h10, slave pready low 3 cycles then prdata='hA5 pslverr=0 -> psel/penable
//    held 4 ACCESS cycles, rsp_rdata='hA5, rsp_valid[1] only.
//  3 Contention: req0 and req1 held continuously for 4 transfers -> grant order 0,1,0,1; IDLE cycle between each.
//  4 Timeout: read 'h20, pready never asserted, TIMEOUT_CYC=16 -> 16 ACCESS cycles, then psel=0, rsp_err=1,
//    rsp_rdata=0, timeout_o pulse coincident with rsp_valid.
//  5 Slave error: write 'h4 with pready=1 pslverr=1 -> rsp_err=1, rsp_valid pulse, next transfer unaffected.
//  6 Reset mid-ACCESS: assert presetn=0 during wait state -> all outputs 0 asynchronously, no rsp_valid; after
//    release, new req0 starts from IDLE with requester 0 priority.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared APB master state encoding and UART register map
//
// Purpose: types and constants shared by the UART APB master arbiter, the UART
//          register slave and their benches.
// Ports:   none (package).

package uart_apb_pkg;

   typedef enum logic [1:0] {
      APB_M_IDLE   = 2'd0,
      APB_M_SETUP  = 2'd1,
      APB_M_ACCESS = 2'd2
   } apb_mstate_e;

   // UART register offsets
   localparam logic [11:0] TX_DATA = 12'h000;
   localparam logic [11:0] RX_DATA = 12'h004;
   localparam logic [11:0] CFG     = 12'h008;
   localparam logic [11:0] CTRL    = 12'h00C;
   localparam logic [11:0] STT     = 12'h010;

endpackage

// File: rtl/apb_uart_bus_arbiter_rr_arbiter.sv
// rtl/apb_uart_bus_arbiter_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
//
// Purpose: picks the first active request starting at the priority pointer;
//          on advance the pointer moves to one past the granted requester.
// Ports:   pclk, presetn  clock, async active-low reset
//          req[N]         active requests
//          advance        the current grant has been taken
//          grant[N]       one-hot grant (all zero when no request)
//          grant_idx      index of the granted requester

module rr_arbiter
   import uart_apb_pkg::*;
#(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand_idx;
   logic             found;
   int               cand;

   // Walk the requesters in circular order beginning at ptr.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found     = 1'b1;
            grant_idx = cand_idx;
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/apb_uart_bus_arbiter.sv
// rtl/apb_uart_bus_arbiter.sv - round-robin sharing of one APB master port to the UART slave
//
// Purpose: accepts one request at a time from NUM_REQ requesters, runs the APB
//          SETUP/ACCESS phases and returns rdata/err to the winner; stalled
//          transfers are aborted after TIMEOUT_CYC ACCESS cycles (0 = never).
// Ports:   pclk, presetn                           clock, async active-low reset
//          req_valid/write/addr/wdata/strb         flattened per-requester requests
//          req_ready                               one-hot accept pulse
//          rsp_valid/rsp_rdata/rsp_err/timeout_o   single-cycle response
//          psel/penable/pwrite/paddr/pstrb/pwdata  APB master outputs
//          pready/pslverr/prdata                   APB slave response

module apb_uart_bus_arbiter
   import uart_apb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*4-1:0]  req_strb,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  timeout_o,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [3:0]            pstrb,
   output logic [DATA_W-1:0]     pwdata,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [DATA_W-1:0]     prdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   apb_mstate_e        state, state_nxt;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               accept, xfer_done, xfer_abort, to_expired;

   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [3:0]         sel_strb;

   logic [IDX_W-1:0]   cap_idx;
   logic               cap_write;
   logic [ADDR_W-1:0]  cap_addr;
   logic [DATA_W-1:0]  cap_wdata;
   logic [3:0]         cap_strb;
   logic [CNT_W-1:0]   to_cnt;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .pclk      (pclk),
      .presetn   (presetn),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign to_expired = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= APB_M_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      psel       = 1'b0;
      penable    = 1'b0;
      accept     = 1'b0;
      xfer_done  = 1'b0;
      xfer_abort = 1'b0;
      unique case (state)
         APB_M_IDLE: begin
            if (|req_valid) begin
               accept    = 1'b1;
               req_ready = grant;
               state_nxt = APB_M_SETUP;
            end
         end
         APB_M_SETUP: begin
            psel      = 1'b1;
            state_nxt = APB_M_ACCESS;
         end
         APB_M_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            // a late pready on the final allowed cycle still completes normally
            if (pready) begin
               xfer_done = 1'b1;
               state_nxt = APB_M_IDLE;
            end else if (to_expired) begin
               xfer_abort = 1'b1;
               state_nxt  = APB_M_IDLE;
            end
         end
         default: state_nxt = APB_M_IDLE;
      endcase
   end

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_strb  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_strb  = req_strb[i*4 +: 4];
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cap_idx   <= '0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_strb  <= '0;
      end else if (accept) begin
         cap_idx   <= grant_idx;
         cap_write <= sel_write;
         cap_addr  <= sel_addr;
         cap_wdata <= sel_wdata;
         cap_strb  <= sel_strb;
      end
   end

   // Counts ACCESS cycles spent waiting; zero outside ACCESS, so SETUP clears it.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         to_cnt <= '0;
      end else if (state == APB_M_ACCESS && !pready) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         timeout_o <= 1'b0;
         if (xfer_done) begin
            rsp_valid[cap_idx] <= 1'b1;
            rsp_rdata          <= cap_write ? '0 : prdata;
            rsp_err            <= pslverr;
         end else if (xfer_abort) begin
            rsp_valid[cap_idx] <= 1'b1;
            rsp_err            <= 1'b1;
            timeout_o          <= 1'b1;
         end
      end
   end

   // APB bus is driven only while selected, idle (all zero) otherwise.
   assign pwrite = psel & cap_write;
   assign paddr  = psel ? cap_addr  : '0;
   assign pwdata = psel ? cap_wdata : '0;
   assign pstrb  = psel ? cap_strb  : '0;

endmodule

// File: tb/tb_apb_uart_bus_arbiter.sv
// tb/tb_apb_uart_bus_arbiter.sv - self-checking bench for apb_uart_bus_arbiter

module tb_apb_uart_bus_arbiter;
   import uart_apb_pkg::*;

   localparam int NR = 2;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             pclk, presetn;
   logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR*4-1:0]  req_strb;
   logic [DW-1:0]    rsp_rdata, pwdata, prdata;
   logic             rsp_err, timeout_o, psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0]    paddr;
   logic [3:0]       pstrb;

   apb_uart_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout_o(timeout_o),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pstrb(pstrb),
      .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_checks, n_errors;

   logic [88:0] all_outs;
   assign all_outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, timeout_o,
                      psel, penable, pwrite, paddr, pstrb, pwdata};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NR-1:0] oh(input int i);
      logic [NR-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
      req_write[id]           = wr;
      req_addr[id*AW +: AW]   = a;
      req_wdata[id*DW +: DW]  = d;
      req_strb[id*4 +: 4]     = s;
   endtask

   task automatic garble(input int id);
      set_req(id, ~req_write[id], 12'($urandom), $urandom, 4'($urandom));
   endtask

   typedef struct {
      int          id;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          wait_n;   // ACCESS cycles with pready low before pready; >= 16 never
      logic        slverr;
      logic [31:0] prd;
      int          exp_lat;
      int          exp_acc;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
   } vec_t;

   vec_t vecs[7];

   task automatic run_single(input vec_t v);
      int   t, acc, setup_n;
      logic done;
      @(negedge pclk);
      req_valid = '0;
      set_req(v.id, v.wr, v.addr, v.wdata, v.strb);
      req_valid[v.id] = 1'b1;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      #1 check("vec_accept_ready", req_ready, oh(v.id));
      t = 0; acc = 0; setup_n = 0; done = 1'b0;
      while (!done && t < 40) begin
         @(negedge pclk);
         t++;
         if (t == 1) begin
            req_valid = '0;
            garble(v.id);
         end
         if (penable) acc++;
         if (psel && !penable) setup_n++;
         pready  = penable && (acc == v.wait_n + 1);
         pslverr = pready && v.slverr;
         prdata  = v.prd;
         #1;
         if (psel) check("vec_apb_fields", {pwrite, paddr, pstrb, pwdata},
                         {v.wr, v.addr, v.strb, v.wdata});
         if (rsp_valid != '0) begin
            done = 1'b1;
            check("vec_latency", t, v.exp_lat);
            check("vec_access_cycles", acc, v.exp_acc);
            check("vec_setup_cycles", setup_n, 1);
            check("vec_rsp_valid", rsp_valid, oh(v.id));
            check("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
            check("vec_rsp_err_to", {rsp_err, timeout_o}, {v.exp_err, v.exp_to});
            check("vec_bus_idle_at_rsp", {psel, penable}, 2'b00);
         end
      end
      check("vec_rsp_within_bound", done, 1'b1);
      @(negedge pclk);
      pready = 1'b0; pslverr = 1'b0;
      #1 check("vec_rsp_single_cycle", {rsp_valid, rsp_err, timeout_o, rsp_rdata}, '0);
   endtask

   task automatic run_contention();
      int grants[$];
      int rsps[$];
      int cyc;
      int exp_order[4] = '{0, 1, 0, 1};
      set_req(0, 1'b1, TX_DATA, 32'h11, 4'hF);
      set_req(1, 1'b0, RX_DATA, 32'h22, 4'h1);
      cyc = 0;
      while (rsps.size() < 4 && cyc < 60) begin
         @(negedge pclk);
         cyc++;
         req_valid = (grants.size() < 4) ? 2'b11 : 2'b00;
         pready = penable; pslverr = 1'b0; prdata = '0;
         #1;
         if (req_ready != '0) begin
            grants.push_back(req_ready[1] ? 1 : 0);
            check("cont_idle_gap_psel", psel, 1'b0);
         end
         if (rsp_valid != '0) rsps.push_back(rsp_valid[1] ? 1 : 0);
      end
      req_valid = '0;
      pready    = 1'b0;
      check("cont_num_rsp", rsps.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check("cont_grant_order", (k < grants.size()) ? grants[k] : 9, exp_order[k]);
         check("cont_rsp_order", (k < rsps.size()) ? rsps[k] : 9, exp_order[k]);
      end
   endtask

   task automatic run_reset_mid();
      int   cyc;
      logic got;
      @(negedge pclk);
      set_req(0, 1'b0, CFG, 32'h0, 4'hF);
      req_valid = 2'b01; pready = 1'b0;
      #1 check("rst_accept", req_ready, 2'b01);
      @(negedge pclk);
      req_valid = '0;
      repeat (2) @(negedge pclk);
      #1 check("rst_in_access", {psel, penable}, 2'b11);
      #1 presetn = 1'b0;
      #1 check("rst_async_outputs", all_outs, '0);
      repeat (2) begin
         @(negedge pclk);
         #1 check("rst_held_outputs", all_outs, '0);
      end
      @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      set_req(0, 1'b1, CTRL, 32'h3, 4'hF);
      set_req(1, 1'b1, TX_DATA, 32'h41, 4'hF);
      req_valid = 2'b11;
      #1 check("rst_prio_req0", req_ready, 2'b01);
      got = 1'b0; cyc = 0;
      while (!got && cyc < 10) begin
         @(negedge pclk);
         cyc++;
         req_valid = '0;
         pready    = penable;
         #1;
         if (rsp_valid != '0) begin
            got = 1'b1;
            check("rst_post_rsp", {rsp_valid, rsp_err}, {2'b01, 1'b0});
         end
      end
      check("rst_post_rsp_seen", got, 1'b1);
      pready = 1'b0;
   endtask

   // Reference model: a transfer accepted in cycle a with slave wait w responds in
   // cycle a+3+w, or a+3+(TO-1) with a timeout when the slave never answers in time.
   task automatic run_random();
      int   cyc, busy_until, acc_cyc, ptr, just_acc, s_acc, w, idx, r;
      logic have_cur, tmo;
      int   c_id, c_wait;
      logic c_wr, c_err;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wdata, c_prd, e_rd;
      logic [3:0]    c_strb;
      logic [NR-1:0] e_gnt, e_rv;
      logic e_er, e_to, e_psel, e_pen;
      @(negedge pclk); req_valid = '0; pready = 1'b0; presetn = 1'b0;
      @(negedge pclk); presetn = 1'b1;
      cyc = 0; busy_until = 0; acc_cyc = 0; ptr = 0; just_acc = -1; s_acc = 0;
      have_cur = 1'b0; c_id = 0; c_wait = 0; c_wr = 0; c_err = 0;
      c_addr = '0; c_wdata = '0; c_prd = '0; c_strb = '0;
      repeat (1500) begin
         @(negedge pclk);
         if (just_acc >= 0) begin
            req_valid[just_acc] = 1'b0;
            garble(just_acc);
            just_acc = -1;
         end
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(2) == 0) begin
                  set_req(i, 1'($urandom), 12'($urandom), $urandom, 4'($urandom));
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         if (penable) s_acc++; else s_acc = 0;
         pready  = penable && (s_acc == c_wait + 1);
         pslverr = pready && c_err;
         prdata  = c_prd;

         e_rv = '0; e_rd = '0; e_er = 1'b0; e_to = 1'b0;
         if (have_cur && cyc == busy_until) begin
            tmo  = (c_wait >= TO);
            e_rv = oh(c_id);
            e_rd = (tmo || c_wr) ? '0 : c_prd;
            e_er = tmo ? 1'b1 : c_err;
            e_to = tmo;
         end
         e_psel = have_cur && cyc > acc_cyc && cyc < busy_until;
         e_pen  = have_cur && cyc > acc_cyc + 1 && cyc < busy_until;
         w = -1;
         if (!have_cur || cyc >= busy_until) begin
            for (int k = 0; k < NR; k++) begin
               idx = (ptr + k) % NR;
               if (w < 0 && req_valid[idx]) w = idx;
            end
         end
         e_gnt = (w >= 0) ? oh(w) : '0;
         #1;
         check("rnd_ready", req_ready, e_gnt);
         check("rnd_rsp", {rsp_valid, rsp_err, timeout_o, rsp_rdata}, {e_rv, e_er, e_to, e_rd});
         check("rnd_apb_phase", {psel, penable}, {e_psel, e_pen});
         if (e_psel) check("rnd_apb_fields", {pwrite, paddr, pstrb, pwdata},
                           {c_wr, c_addr, c_strb, c_wdata});
         if (w >= 0) begin
            c_id    = w;
            c_wr    = req_write[w];
            c_addr  = req_addr[w*AW +: AW];
            c_wdata = req_wdata[w*DW +: DW];
            c_strb  = req_strb[w*4 +: 4];
            r       = $urandom_range(9);
            c_wait  = (r <= 6) ? r % 4 : (r == 7) ? TO - 1 : TO + 4;
            c_err   = ($urandom_range(4) == 0);
            c_prd   = $urandom;
            acc_cyc    = cyc;
            busy_until = cyc + 3 + ((c_wait >= TO) ? TO - 1 : c_wait);
            ptr        = (w + 1) % NR;
            have_cur   = 1'b1;
            just_acc   = w;
         end
         cyc++;
      end
      req_valid = '0;
      pready    = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      presetn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;

      //          id wr    addr     wdata         strb  wait slverr prdata        lat acc exp_rdata     err   to
      vecs[0] = '{0, 1'b1, CFG,     32'h15,       4'hF, 0,  1'b0, 32'hDEAD,      3,  1, 32'h0,        1'b0, 1'b0};
      vecs[1] = '{1, 1'b0, STT,     32'h0,        4'hF, 3,  1'b0, 32'hA5,        6,  4, 32'hA5,       1'b0, 1'b0};
      vecs[2] = '{0, 1'b0, 12'h020, 32'h9,        4'hF, 99, 1'b0, 32'h1234,      18, 16, 32'h0,       1'b1, 1'b1};
      vecs[3] = '{1, 1'b1, RX_DATA, 32'h1234,     4'h3, 0,  1'b1, 32'h5,         3,  1, 32'h0,        1'b1, 1'b0};
      vecs[4] = '{0, 1'b0, CTRL,    32'h0,        4'hF, 0,  1'b0, 32'h0055AA00,  3,  1, 32'h0055AA00, 1'b0, 1'b0};
      vecs[5] = '{1, 1'b0, 12'hFFF, 32'hFFFFFFFF, 4'h8, 15, 1'b0, 32'hCAFEF00D,  18, 16, 32'hCAFEF00D, 1'b0, 1'b0};
      vecs[6] = '{0, 1'b0, TX_DATA, 32'h0,        4'h1, 1,  1'b1, 32'h77,        4,  2, 32'h77,       1'b1, 1'b0};

      repeat (3) @(negedge pclk);
      #1 check("reset_outputs", all_outs, '0);
      @(negedge pclk);
      presetn = 1'b1;

      run_contention();
      for (int k = 0; k < 7; k++) run_single(vecs[k]);
      run_reset_mid();
      run_random();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
